// File: rtl/systolic_array_sequencer_if.sv
// Host-side weight load, input vector stream and result stream of the systolic array sequencer.
interface systolic_array_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int COLUMNS    = 8,
    parameter int ROWS       = COLUMNS
);
    logic                          w_valid;
    logic                          w_ready;
    logic [DATA_WIDTH*COLUMNS-1:0] w_data;
    logic                          d_valid;
    logic                          d_ready;
    logic [DATA_WIDTH*ROWS-1:0]    d_data;
    logic                          r_valid;
    logic [DATA_WIDTH*COLUMNS-1:0] r_data;

    modport master (
        output w_valid, w_data, d_valid, d_data,
        input  w_ready, d_ready, r_valid, r_data
    );

    modport slave (
        input  w_valid, w_data, d_valid, d_data,
        output w_ready, d_ready, r_valid, r_data
    );
endinterface

// File: rtl/systolic_array_sequencer.sv
// Sequences one weight-stationary job: weight load, skewed input streaming, result de-skew and tagging.
// Optional SEQ_PERF_CNT_EN adds o_perf_cycles / o_perf_bubbles job statistics.
module systolic_array_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int COLUMNS     = 8,
    parameter int ROWS        = COLUMNS,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [COUNT_WIDTH-1:0]        i_num_vectors,
    output logic                          o_busy,
    output logic                          o_done,
    systolic_array_sequencer_if.slave     bus,
    output logic [DATA_WIDTH*COLUMNS-1:0] o_array_weight,
    output logic                          o_array_store_weight,
    output logic [DATA_WIDTH*ROWS-1:0]    o_array_data,
    input  logic [DATA_WIDTH*COLUMNS-1:0] i_array_result
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                   o_perf_cycles,
    output logic [31:0]                   o_perf_bubbles
`endif
);

    localparam int LAT  = ROWS + COLUMNS + 1;
    localparam int BW   = $clog2(ROWS + 1);
    localparam int DCW  = $clog2(LAT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic                   r_w_ready;
    logic                   r_d_ready;
    logic [COUNT_WIDTH-1:0] r_num_vec;
    logic [COUNT_WIDTH-1:0] r_vec_cnt;
    logic [BW-1:0]          r_beat_cnt;
    logic [DCW-1:0]         r_drain_cnt;
    logic                   w_store;
    logic                   w_accept;

    assign w_store  = bus.w_valid & r_w_ready;
    assign w_accept = bus.d_valid & r_d_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_LOAD_W;
            S_LOAD_W: if (w_store && r_beat_cnt == BW'(ROWS - 1))
                          w_state_nxt = (r_num_vec == '0) ? S_DRAIN : S_STREAM;
            S_STREAM: if (w_accept && r_vec_cnt == r_num_vec - COUNT_WIDTH'(1))
                          w_state_nxt = S_DRAIN;
            S_DRAIN:  if (r_drain_cnt == DCW'(LAT - 1)) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Ready flags are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_w_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_num_vec   <= '0;
            r_vec_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_w_ready <= (w_state_nxt == S_LOAD_W);
            r_d_ready <= (w_state_nxt == S_STREAM);
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_num_vec   <= i_num_vectors;
                    r_vec_cnt   <= '0;
                    r_beat_cnt  <= '0;
                    r_drain_cnt <= '0;
                end
                S_LOAD_W: if (w_store)  r_beat_cnt  <= r_beat_cnt + BW'(1);
                S_STREAM: if (w_accept) r_vec_cnt   <= r_vec_cnt + COUNT_WIDTH'(1);
                S_DRAIN:                r_drain_cnt <= r_drain_cnt + DCW'(1);
                default: ;
            endcase
        end
    end

    assign o_busy               = (r_state != S_IDLE);
    assign o_done               = (r_state == S_DONE);
    assign bus.w_ready          = r_w_ready;
    assign bus.d_ready          = r_d_ready;
    assign o_array_store_weight = w_store;
    assign o_array_weight       = r_w_ready ? bus.w_data : '0;

    // Input skew: row r passes through r+1 registers; bubbles and idle cycles inject zeros.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_skew
        localparam int D = gr + 1;
        logic [DATA_WIDTH-1:0]       w_in;
        logic [D*DATA_WIDTH-1:0]     r_line;
        logic [(D+1)*DATA_WIDTH-1:0] w_cat;

        assign w_in  = w_accept ? bus.d_data[gr*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign w_cat = {r_line, w_in};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_line <= '0;
            else     r_line <= w_cat[D*DATA_WIDTH-1:0];
        end

        assign o_array_data[gr*DATA_WIDTH +: DATA_WIDTH] = w_cat[(D+1)*DATA_WIDTH-1 -: DATA_WIDTH];
    end

    // Output de-skew: column c waits COLUMNS-1-c cycles so a whole row lines up.
    logic [DATA_WIDTH*COLUMNS-1:0] w_aligned;

    for (genvar gc = 0; gc < COLUMNS; gc++) begin : g_dsk
        localparam int D = COLUMNS - 1 - gc;
        if (D == 0) begin : g_direct
            assign w_aligned[gc*DATA_WIDTH +: DATA_WIDTH] = i_array_result[gc*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_delay
            logic [D*DATA_WIDTH-1:0]     r_line;
            logic [(D+1)*DATA_WIDTH-1:0] w_cat;

            assign w_cat = {r_line, i_array_result[gc*DATA_WIDTH +: DATA_WIDTH]};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_line <= '0;
                else     r_line <= w_cat[D*DATA_WIDTH-1:0];
            end

            assign w_aligned[gc*DATA_WIDTH +: DATA_WIDTH] = w_cat[(D+1)*DATA_WIDTH-1 -: DATA_WIDTH];
        end
    end

    logic [LAT-1:0]                r_tag;
    logic [DATA_WIDTH*COLUMNS-1:0] r_rdata;

    // r_data only captures tagged rows, so it keeps the last result across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag   <= '0;
            r_rdata <= '0;
        end else begin
            r_tag <= {r_tag[LAT-2:0], w_accept};
            if (r_tag[LAT-2]) r_rdata <= w_aligned;
        end
    end

    assign bus.r_valid = r_tag[LAT-1];
    assign bus.r_data  = r_rdata;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cycles  <= '0;
            r_perf_bubbles <= '0;
        end else if (r_state == S_IDLE) begin
            if (i_start) begin
                r_perf_cycles  <= '0;
                r_perf_bubbles <= '0;
            end
        end else if (r_state != S_DONE) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
            if (r_state == S_STREAM && !bus.d_valid) r_perf_bubbles <= r_perf_bubbles + 32'd1;
        end
    end

    assign o_perf_cycles  = r_perf_cycles;
    assign o_perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Bench for systolic_array_sequencer (4x4) with a behavioural weight-stationary array and a result scoreboard.
module tb_systolic_array_sequencer;

    localparam int DW   = 8;
    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int CW   = 16;
    localparam int LAT  = ROWS + COLS + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start;
    logic [CW-1:0]     num_vectors;
    logic              busy;
    logic              done;
    logic [DW*COLS-1:0] array_weight;
    logic              store_weight;
    logic [DW*ROWS-1:0] array_data;
    logic [DW*COLS-1:0] array_result;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]       perf_cycles;
    logic [31:0]       perf_bubbles;
`endif

    always #5 clk = ~clk;

    systolic_array_sequencer_if #(.DATA_WIDTH(DW), .COLUMNS(COLS), .ROWS(ROWS)) bus ();

    systolic_array_sequencer #(
        .DATA_WIDTH(DW), .COLUMNS(COLS), .ROWS(ROWS), .COUNT_WIDTH(CW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_start              (start),
        .i_num_vectors        (num_vectors),
        .o_busy               (busy),
        .o_done               (done),
        .bus                  (bus),
        .o_array_weight       (array_weight),
        .o_array_store_weight (store_weight),
        .o_array_data         (array_data),
        .i_array_result       (array_result)
`ifdef SEQ_PERF_CNT_EN
        ,
        .o_perf_cycles        (perf_cycles),
        .o_perf_bubbles       (perf_bubbles)
`endif
    );

    // Behavioural array: data moves right, partial sums move down, weights shift in from row 0.
    logic [DW-1:0] am_w [ROWS][COLS];
    logic [DW-1:0] am_d [ROWS][COLS];
    logic [DW-1:0] am_p [ROWS][COLS];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    am_w[r][c] <= '0;
                    am_d[r][c] <= '0;
                    am_p[r][c] <= '0;
                end
        end else begin
            if (store_weight) begin
                for (int r = ROWS - 1; r > 0; r--)
                    for (int c = 0; c < COLS; c++) am_w[r][c] <= am_w[r-1][c];
                for (int c = 0; c < COLS; c++) am_w[0][c] <= array_weight[c*DW +: DW];
            end
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    am_d[r][c] <= (c == 0) ? array_data[r*DW +: DW] : am_d[r][c-1];
                    am_p[r][c] <= ((r == 0) ? 8'h00 : am_p[r-1][c]) +
                                  am_w[r][c] * ((c == 0) ? array_data[r*DW +: DW] : am_d[r][c-1]);
                end
        end
    end

    always_comb begin
        array_result = '0;
        for (int c = 0; c < COLS; c++) array_result[c*DW +: DW] = am_p[ROWS-1][c];
    end

    typedef struct {
        logic [DW*COLS-1:0] data;
        int                 cyc;
    } exp_t;

    exp_t               sb_q[$];
    exp_t               e;
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;
    int                 dready_cnt = 0;
    int                 last_acc;
    int                 first_acc;
    logic [DW*COLS-1:0] last_r;
    logic [DW*ROWS-1:0] vecs [0:7];

    always @(posedge clk) cyc <= cyc + 1;

    // Weight row for array row r: a single 1 at column (r+perm)%COLS.
    function automatic logic [DW*COLS-1:0] w_row(input int r, input int perm);
        logic [DW*COLS-1:0] v;
        v = '0;
        v[((r + perm) % COLS)*DW +: DW] = 8'h01;
        return v;
    endfunction

    // With those weights, result column c is input element (c-perm) mod ROWS.
    function automatic logic [DW*COLS-1:0] exp_of(input logic [DW*ROWS-1:0] x, input int perm);
        logic [DW*COLS-1:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[c*DW +: DW] = x[((c - perm + ROWS) % ROWS)*DW +: DW];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.d_ready) dready_cnt++;
            if (rst) begin
                last_r = '0;
            end else if (bus.r_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL r_unexpected cycle %0d actual %h required no result", cyc + 1, bus.r_data);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.r_data !== e.data || cyc + 1 != e.cyc) begin
                        errors++;
                        $display("FAIL r_result actual cycle %0d data %h required cycle %0d data %h",
                                 cyc + 1, bus.r_data, e.cyc, e.data);
                    end
                    last_r = e.data;
                end
            end else begin
                checks++;
                if (bus.r_data !== last_r) begin
                    errors++;
                    $display("FAIL r_hold cycle %0d actual %h required %h", cyc + 1, bus.r_data, last_r);
                end
            end
        end
    end

    task automatic do_start(input int nv, output int s_cyc);
        @(negedge clk);
        start       = 1'b1;
        num_vectors = CW'(nv);
        s_cyc       = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_weights(input int perm, input bit toggle, input string name);
        int beats  = 0;
        int pulses = 0;
        for (int n = 0; n < 40 && beats < ROWS; n++) begin
            if (n > 0) @(negedge clk);
            bus.w_valid = toggle ? (n % 2 == 0) : 1'b1;
            bus.w_data  = w_row(ROWS - 1 - beats, perm);
            #1;
            if (store_weight) pulses++;
            if (bus.w_valid && bus.w_ready) beats++;
        end
        chk({name, "_beats"}, 64'(beats), 64'(ROWS));
        chk({name, "_store_pulses"}, 64'(pulses), 64'(ROWS));
    endtask

    task automatic stream(input int base, input int n, input int gap_at, input int gap_len,
                          input int perm, input string name);
        int idx = 0;
        int gc  = 0;
        int budget = 0;
        @(negedge clk);
        bus.w_valid = 1'b0;
        chk({name, "_stream_entry_dready"}, 64'(bus.d_ready), 64'(1));
        chk({name, "_stream_entry_wready"}, 64'(bus.w_ready), 64'(0));
        while (idx < n && budget < 100) begin
            if (budget > 0) @(negedge clk);
            budget++;
            if (idx == gap_at && gc < gap_len) begin
                bus.d_valid = 1'b0;
                bus.d_data  = '0;
                gc++;
            end else begin
                bus.d_valid = 1'b1;
                bus.d_data  = vecs[base + idx];
                if (bus.d_ready) begin
                    sb_q.push_back('{data: exp_of(vecs[base + idx], perm), cyc: cyc + 1 + LAT});
                    if (idx == 0) first_acc = cyc + 1;
                    last_acc = cyc + 1;
                    idx++;
                end
            end
        end
        chk({name, "_vectors_accepted"}, 64'(idx), 64'(n));
        @(negedge clk);
        bus.d_valid = 1'b0;
        bus.d_data  = '0;
    endtask

    task automatic wait_done(input int exp_cyc, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 80 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk({name, "_done_cycle"}, 64'(cyc + 1), 64'(exp_cyc));
                chk({name, "_busy_in_done"}, 64'(busy), 64'(1));
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout actual no done required done at cycle %0d", name, exp_cyc);
        end
        @(negedge clk);
        chk({name, "_idle_busy"}, 64'(busy), 64'(0));
        chk({name, "_idle_done"}, 64'(done), 64'(0));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, 64'(busy), 64'(0));
        chk({name, "_done"}, 64'(done), 64'(0));
        chk({name, "_wready"}, 64'(bus.w_ready), 64'(0));
        chk({name, "_dready"}, 64'(bus.d_ready), 64'(0));
        chk({name, "_store"}, 64'(store_weight), 64'(0));
        chk({name, "_rvalid"}, 64'(bus.r_valid), 64'(0));
        chk({name, "_aweight"}, 64'(array_weight), 64'(0));
        chk({name, "_adata"}, 64'(array_data), 64'(0));
        chk({name, "_rdata"}, 64'(bus.r_data), 64'(0));
`ifdef SEQ_PERF_CNT_EN
        chk({name, "_perf_cycles"}, 64'(perf_cycles), 64'(0));
        chk({name, "_perf_bubbles"}, 64'(perf_bubbles), 64'(0));
`endif
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s;
        int k;
        int dr0;
        bit seen;

        vecs[0] = 32'h04030201;
        vecs[1] = 32'h807FFF10;
        vecs[2] = 32'hA55A00C3;
        vecs[3] = 32'h11223344;
        vecs[4] = 32'hDEADBEEF;
        vecs[5] = 32'h0F1E2D3C;
        vecs[6] = 32'h01000080;
        vecs[7] = 32'h7E81FE02;

        start       = 1'b0;
        num_vectors = '0;
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.d_valid = 1'b0;
        bus.d_data  = '0;

        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Identity weights, back-to-back vectors.
        do_start(4, s);
        load_weights(0, 1'b0, "ident");
        stream(0, 4, -1, 0, 0, "ident");
        chk("ident_first_latency", 64'(sb_q[0].cyc - first_acc), 64'(LAT));
        wait_done(last_acc + LAT + 1, "ident");

        // Two-cycle bubble between vectors 1 and 2.
        do_start(4, s);
        load_weights(0, 1'b0, "gap");
        stream(0, 4, 2, 2, 0, "gap");
        wait_done(last_acc + LAT + 1, "gap");
`ifdef SEQ_PERF_CNT_EN
        chk("gap_perf_bubbles", 64'(perf_bubbles), 64'(2));
        chk("gap_perf_cycles", 64'(perf_cycles), 64'(ROWS + 6 + LAT));
`endif

        // Toggled weight load, same job.
        do_start(4, s);
        load_weights(0, 1'b1, "toggle");
        stream(0, 4, -1, 0, 0, "toggle");
        wait_done(last_acc + LAT + 1, "toggle");

        // Rotating permutation weights.
        do_start(4, s);
        load_weights(1, 1'b0, "perm1");
        stream(4, 4, -1, 0, 1, "perm1");
        wait_done(last_acc + LAT + 1, "perm1");

        // Empty job.
        do_start(0, s);
        dr0 = dready_cnt;
        load_weights(0, 1'b0, "nv0");
        @(negedge clk);
        bus.w_valid = 1'b0;
        wait_done(s + ROWS + LAT + 1, "nv0");
        chk("nv0_no_dready", 64'(dready_cnt - dr0), 64'(0));

        // start held high through a whole job.
        @(negedge clk);
        start       = 1'b1;
        num_vectors = '0;
        bus.w_valid = 1'b1;
        bus.w_data  = w_row(0, 0);
        s           = cyc + 1;
        seen        = 1'b0;
        k           = 0;
        for (int n = 0; n < 80 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                k    = cyc + 1;
            end
        end
        chk("held_first_done_cycle", 64'(k), 64'(s + ROWS + LAT + 1));
        @(negedge clk);
        chk("held_idle_between_jobs", 64'(busy), 64'(0));
        @(negedge clk);
        chk("held_second_job_busy", 64'(busy), 64'(1));
        chk("held_second_job_wready", 64'(bus.w_ready), 64'(1));
        start = 1'b0;
        wait_done(k + 1 + ROWS + LAT + 1, "held_second");
        bus.w_valid = 1'b0;

        // Reset in the middle of streaming.
        do_start(8, s);
        load_weights(0, 1'b0, "abort");
        stream(0, 3, -1, 0, 0, "abort");
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk_all_zero("abort_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done_or_busy", 64'(seen), 64'(0));

        // Recovery job after the abort.
        do_start(4, s);
        load_weights(3, 1'b0, "perm3");
        stream(4, 4, -1, 0, 3, "perm3");
        wait_done(last_acc + LAT + 1, "perm3");

        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
